// File: rtl/uart_receiver_controller.sv
// Command-frame decoder: turns received UART bytes into register-file and ALU strobes.
// Every output is registered, so a strobe appears in the cycle after the byte that completes it.
module uart_receiver_controller #(
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter int unsigned            ADDR_WIDTH     = 4,
  parameter int unsigned            FUNC_WIDTH     = 4,
  parameter int unsigned            TIMEOUT_CYCLES = 4096,
  parameter logic [DATA_WIDTH-1:0]  CMD_RF_WR      = 'hAA,
  parameter logic [DATA_WIDTH-1:0]  CMD_RF_RD      = 'hBB,
  parameter logic [DATA_WIDTH-1:0]  CMD_ALU_OP     = 'hCC,
  parameter logic [DATA_WIDTH-1:0]  CMD_ALU_NOP    = 'hDD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] receiver_parallel_data,
  input  logic                  receiver_parallel_data_valid,
  input  logic                  uart_receiver_controller_en,
  output logic [ADDR_WIDTH-1:0] register_file_address,
  output logic [DATA_WIDTH-1:0] register_file_write_data,
  output logic                  register_file_write_en,
  output logic                  register_file_read_en,
  output logic [FUNC_WIDTH-1:0] alu_function,
  output logic                  alu_enable,
  output logic                  alu_clk_en,
  output logic                  frame_error
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUNC
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [FUNC_WIDTH-1:0] func_q, func_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  ae_q, ae_d;
  logic                  ace_q, ace_d;
  logic                  ferr_q, ferr_d;

  logic                  vld;
  logic [DATA_WIDTH-1:0] rx;

  assign vld = receiver_parallel_data_valid;
  assign rx  = receiver_parallel_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    func_d  = func_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    ae_d    = 1'b0;
    ferr_d  = 1'b0;

    // Inter-byte watchdog; a byte arriving on the expiry cycle still wins.
    if (state_q != IDLE && !vld) begin
      if (cnt_q == TO_LAST) begin
        ferr_d  = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    if (vld) begin
      unique case (state_q)
        IDLE: begin
          if (uart_receiver_controller_en) begin
            if      (rx == CMD_RF_WR)   state_d = WR_ADDR;
            else if (rx == CMD_RF_RD)   state_d = RD_ADDR;
            else if (rx == CMD_ALU_OP)  state_d = OP_A;
            else if (rx == CMD_ALU_NOP) state_d = ALU_FUNC;
            else                        ferr_d  = 1'b1;
          end
        end
        WR_ADDR: begin
          addr_d  = rx[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: begin
          wdata_d = rx;
          we_d    = 1'b1;
          state_d = IDLE;
        end
        RD_ADDR: begin
          addr_d  = rx[ADDR_WIDTH-1:0];
          re_d    = 1'b1;
          state_d = IDLE;
        end
        OP_A: begin
          addr_d  = '0;
          wdata_d = rx;
          we_d    = 1'b1;
          state_d = OP_B;
        end
        OP_B: begin
          addr_d  = ADDR_WIDTH'(1);
          wdata_d = rx;
          we_d    = 1'b1;
          state_d = ALU_FUNC;
        end
        ALU_FUNC: begin
          func_d  = rx[FUNC_WIDTH-1:0];
          ae_d    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    ace_d = ae_d | ae_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      func_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ae_q    <= 1'b0;
      ace_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      func_q  <= func_d;
      we_q    <= we_d;
      re_q    <= re_d;
      ae_q    <= ae_d;
      ace_q   <= ace_d;
      ferr_q  <= ferr_d;
    end
  end

  assign register_file_address    = addr_q;
  assign register_file_write_data = wdata_q;
  assign register_file_write_en   = we_q;
  assign register_file_read_en    = re_q;
  assign alu_function             = func_q;
  assign alu_enable               = ae_q;
  assign alu_clk_en               = ace_q;
  assign frame_error              = ferr_q;

endmodule
